// File: rtl/axi4_lite_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axi4_lite_if                                                    |
// | Brief    : AXI4-Lite channel bundle with master (m) and slave (s) views    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface axi4_lite_if #(
   parameter int AW = 4,
   parameter int DW = 32
);
   logic [AW-1:0]   awaddr;
   logic [2:0]      awprot;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   logic [AW-1:0]   araddr;
   logic [2:0]      arprot;
   logic            arvalid;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;

   modport m (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );

   modport s (
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axi4_lite_master                                                |
// | Brief    : Single-outstanding AXI4-Lite initiator driven by a cmd/rsp pair |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module axi4_lite_master #(
   parameter int         AW   = 4,
   parameter int         DW   = 32,
   parameter logic [2:0] PROT = 3'b000
) (
   input  logic            aclk,
   input  logic            areset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_we,
   input  logic [AW-1:0]   cmd_addr,
   input  logic [DW-1:0]   cmd_wdata,
   input  logic [DW/8-1:0] cmd_wstrb,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_we,
   output logic [DW-1:0]   rsp_rdata,
   output logic [1:0]      rsp_resp,
   axi4_lite_if.m          axi
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR   = 3'd1,
      S_RD_A = 3'd2,
      S_RD_D = 3'd3,
      S_RSP  = 3'd4
   } state_t;

   state_t            r_state,     w_state_nxt;
   logic              r_cmd_ready, w_cmd_ready_nxt;
   logic              r_awvalid,   w_awvalid_nxt;
   logic              r_wvalid,    w_wvalid_nxt;
   logic              r_bready,    w_bready_nxt;
   logic              r_arvalid,   w_arvalid_nxt;
   logic              r_rready,    w_rready_nxt;
   logic              r_aw_done,   w_aw_done_nxt;
   logic              r_w_done,    w_w_done_nxt;
   logic              r_rsp_valid, w_rsp_valid_nxt;
   logic              r_rsp_we,    w_rsp_we_nxt;
   logic [DW-1:0]     r_rsp_rdata, w_rsp_rdata_nxt;
   logic [1:0]        r_rsp_resp,  w_rsp_resp_nxt;
   logic [AW-1:0]     r_addr,      w_addr_nxt;
   logic [DW-1:0]     r_wdata,     w_wdata_nxt;
   logic [DW/8-1:0]   r_wstrb,     w_wstrb_nxt;

   logic w_aw_fire, w_w_fire, w_b_fire, w_ar_fire, w_r_fire;

   assign w_aw_fire = r_awvalid & axi.awready;
   assign w_w_fire  = r_wvalid  & axi.wready;
   assign w_b_fire  = r_bready  & axi.bvalid;
   assign w_ar_fire = r_arvalid & axi.arready;
   assign w_r_fire  = r_rready  & axi.rvalid;

   always_comb begin
      w_state_nxt     = r_state;
      w_awvalid_nxt   = r_awvalid;
      w_wvalid_nxt    = r_wvalid;
      w_bready_nxt    = r_bready;
      w_arvalid_nxt   = r_arvalid;
      w_rready_nxt    = r_rready;
      w_aw_done_nxt   = r_aw_done;
      w_w_done_nxt    = r_w_done;
      w_rsp_valid_nxt = r_rsp_valid;
      w_rsp_we_nxt    = r_rsp_we;
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_rsp_resp_nxt  = r_rsp_resp;
      w_addr_nxt      = r_addr;
      w_wdata_nxt     = r_wdata;
      w_wstrb_nxt     = r_wstrb;

      unique case (r_state)
         S_IDLE: begin
            if (cmd_valid && r_cmd_ready) begin
               w_addr_nxt  = cmd_addr;
               w_wdata_nxt = cmd_wdata;
               w_wstrb_nxt = cmd_wstrb;
               if (cmd_we) begin
                  w_state_nxt   = S_WR;
                  w_awvalid_nxt = 1'b1;
                  w_wvalid_nxt  = 1'b1;
                  w_aw_done_nxt = 1'b0;
                  w_w_done_nxt  = 1'b0;
               end else begin
                  w_state_nxt   = S_RD_A;
                  w_arvalid_nxt = 1'b1;
               end
            end
         end
         S_WR: begin
            if (w_aw_fire) begin
               w_awvalid_nxt = 1'b0;
               w_aw_done_nxt = 1'b1;
            end
            if (w_w_fire) begin
               w_wvalid_nxt = 1'b0;
               w_w_done_nxt = 1'b1;
            end
            // A B that shows up before both address and data are taken is left pending.
            if (w_b_fire) begin
               w_bready_nxt    = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_we_nxt    = 1'b1;
               w_rsp_rdata_nxt = '0;
               w_rsp_resp_nxt  = axi.bresp;
               w_state_nxt     = S_RSP;
            end else begin
               w_bready_nxt = w_aw_done_nxt & w_w_done_nxt;
            end
         end
         S_RD_A: begin
            if (w_ar_fire) begin
               w_arvalid_nxt = 1'b0;
               w_rready_nxt  = 1'b1;
               w_state_nxt   = S_RD_D;
            end
         end
         S_RD_D: begin
            if (w_r_fire) begin
               w_rready_nxt    = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_we_nxt    = 1'b0;
               w_rsp_rdata_nxt = axi.rdata;
               w_rsp_resp_nxt  = axi.rresp;
               w_state_nxt     = S_RSP;
            end
         end
         S_RSP: begin
            if (rsp_ready) begin
               w_rsp_valid_nxt = 1'b0;
               w_state_nxt     = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_we    <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cmd_ready <= w_cmd_ready_nxt;
         r_awvalid   <= w_awvalid_nxt;
         r_wvalid    <= w_wvalid_nxt;
         r_bready    <= w_bready_nxt;
         r_arvalid   <= w_arvalid_nxt;
         r_rready    <= w_rready_nxt;
         r_aw_done   <= w_aw_done_nxt;
         r_w_done    <= w_w_done_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_we    <= w_rsp_we_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_rsp_resp  <= w_rsp_resp_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_wstrb     <= w_wstrb_nxt;
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_we      = r_rsp_we;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_resp    = r_rsp_resp;

   assign axi.awaddr  = r_addr;
   assign axi.awprot  = PROT;
   assign axi.awvalid = r_awvalid;
   assign axi.wdata   = r_wdata;
   assign axi.wstrb   = r_wstrb;
   assign axi.wvalid  = r_wvalid;
   assign axi.bready  = r_bready;
   assign axi.araddr  = r_addr;
   assign axi.arprot  = PROT;
   assign axi.arvalid = r_arvalid;
   assign axi.rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axi4_lite_master                                             |
// | Brief    : Directed self-checking bench with a register-file slave model   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_axi4_lite_master;
   localparam int AW = 4;
   localparam int DW = 32;

   logic          aclk      = 1'b0;
   logic          areset    = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_we    = 1'b0;
   logic [AW-1:0] cmd_addr  = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [3:0]    cmd_wstrb = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic          rsp_we;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;

   axi4_lite_if #(.AW(AW), .DW(DW)) axi ();

   axi4_lite_master #(.AW(AW), .DW(DW), .PROT(3'b000)) dut (
      .aclk      (aclk),
      .areset    (areset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_wstrb (cmd_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_we    (rsp_we),
      .rsp_rdata (rsp_rdata),
      .rsp_resp  (rsp_resp),
      .axi       (axi)
   );

   always #5 aclk = ~aclk;

   int total = 0;
   int bad   = 0;

   // slave model configuration and state
   int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   int         aw_w = 0, w_w = 0, b_w = 0, ar_w = 0, r_w = 0;
   bit         early_b = 1'b0;
   logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   bit         got_aw = 0, got_w = 0, b_pend = 0, r_pend = 0;
   bit         hs_aw = 0, hs_w = 0, hs_b = 0, hs_ar = 0, hs_r = 0;
   logic [1:0] wa = '0, ra = '0;
   logic [31:0] wd = '0;
   logic [3:0]  ws = '0;
   logic [31:0] regs [4];
   logic [31:0] mdl  [4];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge aclk);
      #1;
   endtask

   // Slave: decides readies/valids at each falling edge; hs_* predict the next rising edge.
   initial begin
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;    axi.rresp = 2'b00;
      forever begin
         @(negedge aclk);
         if (areset) begin
            axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
            axi.arready = 1'b0; axi.rvalid = 1'b0;
            got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
            hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
            aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
         end else begin
            if (hs_aw) begin got_aw = 1; aw_w = 0; end
            if (hs_w)  begin got_w  = 1; w_w  = 0; end
            if (hs_b)  begin axi.bvalid = 1'b0; b_pend = 0; b_w = 0; end
            if (hs_ar) begin r_pend = 1; ar_w = 0; end
            if (hs_r)  begin axi.rvalid = 1'b0; r_pend = 0; r_w = 0; end
            if (got_aw && got_w) begin
               for (int i = 0; i < 4; i++)
                  if (ws[i]) regs[wa][8*i +: 8] = wd[8*i +: 8];
               got_aw = 0; got_w = 0; b_pend = 1;
            end
            axi.awready = 1'b0;
            if (axi.awvalid && !got_aw) begin
               if (aw_w >= aw_dly) begin axi.awready = 1'b1; wa = axi.awaddr[3:2]; end
               else aw_w++;
            end
            axi.wready = 1'b0;
            if (axi.wvalid && !got_w) begin
               if (w_w >= w_dly) begin axi.wready = 1'b1; wd = axi.wdata; ws = axi.wstrb; end
               else w_w++;
            end
            if (b_pend || (early_b && got_aw)) begin
               if (b_w >= b_dly) begin axi.bvalid = 1'b1; axi.bresp = bresp_cfg; end
               else b_w++;
            end
            axi.arready = 1'b0;
            if (axi.arvalid && !r_pend) begin
               if (ar_w >= ar_dly) begin axi.arready = 1'b1; ra = axi.araddr[3:2]; end
               else ar_w++;
            end
            if (r_pend && !axi.rvalid) begin
               if (r_w >= r_dly) begin axi.rvalid = 1'b1; axi.rdata = regs[ra]; axi.rresp = rresp_cfg; end
               else r_w++;
            end
            hs_aw = axi.awvalid && axi.awready;
            hs_w  = axi.wvalid  && axi.wready;
            hs_b  = axi.bvalid  && axi.bready;
            hs_ar = axi.arvalid && axi.arready;
            hs_r  = axi.rvalid  && axi.rready;
         end
      end
   end

   task automatic do_cmd(input logic we, input logic [3:0] addr, input logic [31:0] wdat,
                         input logic [3:0] st, input int hold, output logic ok,
                         output logic o_we, output logic [31:0] o_data, output logic [1:0] o_resp);
      int n;
      ok = 1'b1;
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdat; cmd_wstrb = st;
      n = 0;
      while (!cmd_ready && n < 50) begin step(); n++; end
      if (n >= 50) ok = 1'b0;
      step();
      cmd_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 100) begin step(); n++; end
      if (n >= 100) ok = 1'b0;
      o_we = rsp_we; o_data = rsp_rdata; o_resp = rsp_resp;
      repeat (hold) step();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic        ok, r_we, we;
      logic [31:0] r_data, wdat;
      logic [1:0]  r_resp, idx, prev_idx;
      logic [3:0]  st;
      int          hold;

      for (int i = 0; i < 4; i++) regs[i] = 32'h0;
      regs[2] = 32'h1234_5678;
      prev_idx = 2'd0;

      // reset state
      step(); step();
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_awvalid", axi.awvalid, 0);
      chk("rst_wvalid", axi.wvalid, 0);
      chk("rst_arvalid", axi.arvalid, 0);
      chk("rst_bready", axi.bready, 0);
      chk("rst_rready", axi.rready, 0);
      chk("rst_awaddr", axi.awaddr, 0);
      areset = 1'b0;
      step();
      chk("idle_cmd_ready", cmd_ready, 1);

      // 1: zero-wait write
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
      step();
      cmd_valid = 1'b0;
      chk("w1_awvalid", axi.awvalid, 1);
      chk("w1_wvalid", axi.wvalid, 1);
      chk("w1_cmd_ready", cmd_ready, 0);
      chk("w1_awaddr", axi.awaddr, 4'h4);
      chk("w1_wdata", axi.wdata, 32'hDEAD_BEEF);
      chk("w1_wstrb", axi.wstrb, 4'hF);
      chk("w1_awprot", axi.awprot, 3'b000);
      step();
      chk("w1_aw_low", axi.awvalid, 0);
      chk("w1_w_low", axi.wvalid, 0);
      chk("w1_bready", axi.bready, 1);
      step();
      chk("w1_rsp_valid", rsp_valid, 1);
      chk("w1_bready_low", axi.bready, 0);
      chk("w1_rsp_resp", rsp_resp, 2'b00);
      chk("w1_rsp_rdata", rsp_rdata, 0);
      chk("w1_rsp_we", rsp_we, 1);
      step();
      chk("w1_rsp_drop", rsp_valid, 0);
      chk("w1_cmd_ready_back", cmd_ready, 1);
      chk("w1_slave_reg", regs[1], 32'hDEAD_BEEF);

      // 2: zero-wait read
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 4'h8;
      step();
      cmd_valid = 1'b0;
      chk("r2_arvalid", axi.arvalid, 1);
      chk("r2_araddr", axi.araddr, 4'h8);
      step();
      chk("r2_ar_low", axi.arvalid, 0);
      chk("r2_rready", axi.rready, 1);
      step();
      chk("r2_rsp_valid", rsp_valid, 1);
      chk("r2_rdata", rsp_rdata, 32'h1234_5678);
      chk("r2_rsp_we", rsp_we, 0);
      chk("r2_rsp_resp", rsp_resp, 2'b00);
      chk("r2_rready_low", axi.rready, 0);
      step();
      chk("r2_rsp_drop", rsp_valid, 0);

      // 3: W accepted 3 cycles after AW, slave offers B early
      w_dly = 3; early_b = 1'b1;
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'hC; cmd_wdata = 32'hCAFE_F00D; cmd_wstrb = 4'b0011;
      step();
      cmd_valid = 1'b0;
      chk("w3_awvalid", axi.awvalid, 1);
      chk("w3_wvalid", axi.wvalid, 1);
      step();
      chk("w3_aw_low", axi.awvalid, 0);
      for (int i = 0; i < 3; i++) begin
         chk("w3_w_held", axi.wvalid, 1);
         chk("w3_bready_low", axi.bready, 0);
         chk("w3_no_rsp", rsp_valid, 0);
         step();
      end
      chk("w3_w_low", axi.wvalid, 0);
      chk("w3_bready", axi.bready, 1);
      step();
      chk("w3_rsp_valid", rsp_valid, 1);
      step();
      chk("w3_slave_reg", regs[3], 32'h0000_F00D);
      w_dly = 0; early_b = 1'b0;

      // 4: SLVERR passed through, response held under backpressure
      bresp_cfg = 2'b10; rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'h0; cmd_wdata = 32'h0BAD_0BAD; cmd_wstrb = 4'hF;
      step();
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 4'h8;
      step(); step();
      for (int i = 0; i < 6; i++) begin
         chk("e4_rsp_valid", rsp_valid, 1);
         chk("e4_rsp_resp", rsp_resp, 2'b10);
         chk("e4_rsp_we", rsp_we, 1);
         chk("e4_rsp_rdata", rsp_rdata, 0);
         chk("e4_cmd_ready", cmd_ready, 0);
         if (i < 5) step();
      end
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      step();
      chk("e4_rsp_drop", rsp_valid, 0);
      chk("e4_arvalid", axi.arvalid, 0);
      bresp_cfg = 2'b00;

      // 5: reset while AR is stalled
      ar_dly = 100;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 4'h8;
      step();
      cmd_valid = 1'b0;
      step();
      chk("x5_ar_stall", axi.arvalid, 1);
      #2 areset = 1'b1;
      #1;
      chk("x5_ar_cleared", axi.arvalid, 0);
      chk("x5_rsp_cleared", rsp_valid, 0);
      chk("x5_cmd_ready_rst", cmd_ready, 0);
      step();
      ar_dly = 0;
      areset = 1'b0;
      step();
      chk("x5_cmd_ready_back", cmd_ready, 1);
      do_cmd(1'b0, 4'h8, 32'h0, 4'h0, 0, ok, r_we, r_data, r_resp);
      chk("x5_read_done", ok, 1);
      chk("x5_read_data", r_data, 32'h1234_5678);
      chk("x5_read_resp", r_resp, 2'b00);

      // 6: back-to-back traffic with random slave and consumer delays
      for (int i = 0; i < 4; i++) begin
         regs[i] = 32'h1111_1111 * (i + 1);
         mdl[i]  = 32'h1111_1111 * (i + 1);
      end
      for (int k = 0; k < 20; k++) begin
         aw_dly = int'($urandom_range(0, 3)); w_dly = int'($urandom_range(0, 3));
         b_dly  = int'($urandom_range(0, 3)); ar_dly = int'($urandom_range(0, 3));
         r_dly  = int'($urandom_range(0, 3));
         hold   = int'($urandom_range(0, 2));
         wdat   = $urandom;
         st     = 4'($urandom_range(0, 15));
         if (k % 2 == 1) begin
            we  = 1'b0;
            idx = prev_idx;
         end else begin
            we  = 1'($urandom_range(0, 1));
            idx = 2'($urandom_range(0, 3));
         end
         prev_idx = idx;
         do_cmd(we, {idx, 2'b00}, wdat, st, hold, ok, r_we, r_data, r_resp);
         chk("b2b_done", ok, 1);
         chk("b2b_we_echo", r_we, we);
         chk("b2b_resp", r_resp, 2'b00);
         if (we) begin
            for (int i = 0; i < 4; i++)
               if (st[i]) mdl[idx][8*i +: 8] = wdat[8*i +: 8];
            chk("b2b_wr_rdata", r_data, 0);
         end else begin
            chk("b2b_rd_data", r_data, mdl[idx]);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
